// File: rtl/multicycle_main_decoder.sv
// Main control FSM with ALU and instruction decoders for the multicycle ARM-subset datapath.
// Issues unconditional write/branch requests; the conditional-execution unit gates them.
module multicycle_main_decoder (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    output logic [3:0] State,
    output logic       PCS,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic [1:0] FlagW,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTER = 4'd6;
    localparam logic [3:0] EXECUTEI = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       alu_op;
    logic       branch;
    logic [3:0] cmd;
    logic       s_bit;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Undefined opcodes and illegal encodings both fall back to FETCH.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        RegW      = 1'b0;
        MemW      = 1'b0;
        alu_op    = 1'b0;
        branch    = 1'b0;
        case (state_q)
            FETCH: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECUTER: begin
                alu_op = 1'b1;
            end
            EXECUTEI: begin
                ALUSrcB = 2'b01;
                alu_op  = 1'b1;
            end
            ALUWB: begin
                RegW = 1'b1;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: begin
                IRWrite = 1'b0;
            end
        endcase
    end

    assign cmd   = Funct[4:1];
    assign s_bit = Funct[0];

    // Logical ops only touch N,Z; arithmetic ops also update C,V.
    always_comb begin
        ALUControl = 2'b00;
        FlagW      = 2'b00;
        if (alu_op) begin
            case (cmd)
                4'b0100: begin ALUControl = 2'b00; FlagW = {s_bit, s_bit}; end
                4'b0010: begin ALUControl = 2'b01; FlagW = {s_bit, s_bit}; end
                4'b0000: begin ALUControl = 2'b10; FlagW = {s_bit, 1'b0};  end
                4'b1100: begin ALUControl = 2'b11; FlagW = {s_bit, 1'b0};  end
                default: begin ALUControl = 2'b00; FlagW = 2'b00;          end
            endcase
        end
    end

    assign PCS    = ((Rd == 4'd15) & RegW) | branch;
    assign ImmSrc = Op;
    assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};
    assign State  = state_q;

endmodule
